audio_clip_sequencer: RTL and testbench
=======================================

Name: audio_clip_sequencer

Overview:
Playback controller that sequences the audio sample datapath: accepts clip commands (start address, length, repeat count) into a small FIFO and plays them back-to-back. It owns the sample-rate timebase and drives the sample address and strobe into the lookup-table/PWM path. Between clips it inserts a fixed muted gap. Replaces free-running address generation with commanded playback.

Parameters:
CLOCK_RATE, 3_125_000, system clock frequency in Hz
SAMPLE_RATE, 16_000, playback sample rate in Hz; DIVIDER = CLOCK_RATE/SAMPLE_RATE (195 at defaults)
FIFO_DEPTH, 4, command FIFO entries (power of two, 2..8)
GAP_SAMPLES, 160, muted sample periods inserted after each clip (0 = no gap)

Ports:
clk  input  1  system clock
rst_n  input  1  reset, synchronous, active-low
enable  input  1  run; low freezes the timebase and playback state
cmd_valid  input  1  command offered
cmd_ready  output  1  command FIFO can accept
cmd_start  input  16  first sample address of clip
cmd_len  input  16  clip length in samples
cmd_loops  input  4  extra repeats (0 = play once)
abort  input  1  flush FIFO and stop current clip
sample_addr  output  16  address to audio lookup table
sample_strobe  output  1  one-cycle pulse: sample_addr just updated
mute  output  1  high = downstream forces midscale/zero output
busy  output  1  high in any state other than IDLE, or FIFO non-empty
clip_done  output  1  one-cycle pulse when a clip (all loops) completes
fifo_level  output  4  FIFO occupancy, 0..FIFO_DEPTH

Behaviour:
- Reset (rst_n low at clk edge): state IDLE, FIFO empty, sample_addr=0, sample_strobe=0, mute=1, busy=0, clip_done=0, fifo_level=0, timebase=0; cmd_ready=0 while rst_n low.
- Handshake: push when cmd_valid && cmd_ready. cmd_ready = (registered fifo_level < FIFO_DEPTH) && !abort && rst_n; a same-cycle pop does not free space for a push. cmd_len==0 commands are accepted and discarded (not stored).
- Timebase: counter 0..DIVIDER-1, advances only when enable=1 and state is PLAY or GAP; tick on the cycle counter==DIVIDER-1 (counter then wraps to 0). Counter cleared on entry to LOAD and GAP.
- IDLE: mute=1. If FIFO non-empty and enable -> LOAD.
- LOAD (1 cycle): pop head; latch start, remaining=len-1, loops_left=loops; sample_addr<=start; sample_strobe<=1 next cycle -> PLAY.
- PLAY: mute=!enable. On tick: if remaining>0: sample_addr+1 (mod 2^16 wrap), remaining-1, strobe. If remaining==0 and loops_left>0: loops_left-1, sample_addr<=start, remaining<=len-1, strobe. If remaining==0 and loops_left==0: clip_done pulse, no strobe -> GAP (or IDLE if GAP_SAMPLES==0).
- GAP: mute=1, no strobes; after GAP_SAMPLES ticks -> IDLE.
- Timing: clip of length L, loops N gives L*(N+1) strobes; first strobe 1 cycle after LOAD, subsequent strobes exactly DIVIDER cycles apart; clip_done DIVIDER cycles after last strobe.
- enable low: timebase, state, counters frozen; pushes and abort still honoured; mute=1.
- abort (synchronous, priority below reset): next cycle FIFO empty, state IDLE, mute=1, sample_addr=0, no clip_done; push in the abort cycle is refused.
- Command push in same cycle as LOAD pop with level < FIFO_DEPTH: both occur, level unchanged.

Test Plan:
- Reset then push {start=100,len=3,loops=0}, enable=1 -> strobes at addr 100,101,102 spaced 195 cycles; clip_done 195 cycles after third; 160 muted ticks; busy falls.
- Push {start=0xFFFE,len=4,loops=1} -> addr sequence FFFE,FFFF,0000,0001,FFFE,FFFF,0000,0001; one clip_done only.
- Push 5 commands back-to-back while IDLE with enable=0 -> first 4 accepted, cmd_ready=0 at level 4, fifo_level=4; len=0 command accepted but level unchanged.
- During PLAY drop enable for 1000 cycles -> no strobes, mute=1; resume, next strobe lands exactly remaining timebase count later, address continues.
- Assert abort mid-clip with 2 queued -> next cycle fifo_level=0, mute=1, sample_addr=0, no clip_done, push in abort cycle refused.
- rst_n low mid-PLAY for one cycle -> all outputs at reset values next cycle; queued commands lost.

Source files
------------

// File: rtl/audio_clip_sequencer_if.sv
// Clip command channel: a command transfers on any clock edge where cmd_valid and
// cmd_ready are both high; the master holds the payload stable while cmd_valid is high.
interface audio_clip_sequencer_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_start;
    logic [15:0] cmd_len;
    logic [3:0]  cmd_loops;

    modport master (
        output cmd_valid,
        output cmd_start,
        output cmd_len,
        output cmd_loops,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_start,
        input  cmd_len,
        input  cmd_loops,
        output cmd_ready
    );
endinterface

// File: rtl/audio_clip_sequencer.sv
// Commanded audio playback: queues clip commands, owns the sample-rate timebase and
// steps the lookup-table address once per sample period, with a muted gap after each clip.
module audio_clip_sequencer #(
    parameter int CLOCK_RATE  = 3_125_000,
    parameter int SAMPLE_RATE = 16_000,
    parameter int FIFO_DEPTH  = 4,
    parameter int GAP_SAMPLES = 160
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       enable,
    input  logic                       abort,
    audio_clip_sequencer_if.slave      cmd,
    output logic [15:0]                sample_addr,
    output logic                       sample_strobe,
    output logic                       mute,
    output logic                       busy,
    output logic                       clip_done,
    output logic [3:0]                 fifo_level,
    output logic [1:0]                 dbg_state
);

    localparam int DIVIDER = CLOCK_RATE / SAMPLE_RATE;
    localparam int TB_W    = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;
    localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    localparam logic [TB_W-1:0] TB_LAST  = TB_W'(DIVIDER - 1);
    localparam logic [15:0]     GAP_LAST = 16'(GAP_SAMPLES - 1);
    localparam logic [3:0]      DEPTH_L  = 4'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_PLAY = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [TB_W-1:0]   tb_cnt_q, tb_cnt_d;
    logic [15:0]       gap_cnt_q, gap_cnt_d;
    logic [15:0]       start_q, start_d;
    logic [15:0]       len_q, len_d;
    logic [15:0]       remaining_q, remaining_d;
    logic [3:0]        loops_left_q, loops_left_d;
    logic [15:0]       addr_q, addr_d;
    logic              strobe_q, strobe_d;
    logic              done_q, done_d;
    logic              mute_q, mute_d;
    logic              busy_q, busy_d;
    logic [3:0]        level_q, level_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [15:0]       fifo_start_q [FIFO_DEPTH];
    logic [15:0]       fifo_start_d [FIFO_DEPTH];
    logic [15:0]       fifo_len_q   [FIFO_DEPTH];
    logic [15:0]       fifo_len_d   [FIFO_DEPTH];
    logic [3:0]        fifo_loops_q [FIFO_DEPTH];
    logic [3:0]        fifo_loops_d [FIFO_DEPTH];

    logic cmd_ready;
    logic push;
    logic pop;
    logic run_timebase;
    logic tick;

    // Space is judged on the registered level, so a pop in the same cycle never frees a slot.
    assign cmd_ready     = (level_q < DEPTH_L) && !abort && rst_n;
    assign cmd.cmd_ready = cmd_ready;

    assign push         = cmd.cmd_valid && cmd_ready && (cmd.cmd_len != 16'd0);
    assign pop          = (state_q == S_LOAD) && enable;
    assign run_timebase = enable && ((state_q == S_PLAY) || (state_q == S_GAP));
    assign tick         = run_timebase && (tb_cnt_q == TB_LAST);

    always_comb begin
        state_d      = state_q;
        tb_cnt_d     = tb_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        start_d      = start_q;
        len_d        = len_q;
        remaining_d  = remaining_q;
        loops_left_d = loops_left_q;
        addr_d       = addr_q;
        strobe_d     = 1'b0;
        done_d       = 1'b0;
        level_d      = level_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        fifo_start_d = fifo_start_q;
        fifo_len_d   = fifo_len_q;
        fifo_loops_d = fifo_loops_q;

        if (run_timebase) begin
            tb_cnt_d = tick ? '0 : tb_cnt_q + 1'b1;
        end

        if (push) begin
            fifo_start_d[wr_ptr_q] = cmd.cmd_start;
            fifo_len_d[wr_ptr_q]   = cmd.cmd_len;
            fifo_loops_d[wr_ptr_q] = cmd.cmd_loops;
            wr_ptr_d               = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   level_d = level_q + 4'd1;
            2'b01:   level_d = level_q - 4'd1;
            default: level_d = level_q;
        endcase

        case (state_q)
            S_IDLE: begin
                if (enable && (level_q != 4'd0)) begin
                    state_d  = S_LOAD;
                    tb_cnt_d = '0;
                end
            end
            S_LOAD: begin
                if (enable) begin
                    start_d      = fifo_start_q[rd_ptr_q];
                    len_d        = fifo_len_q[rd_ptr_q];
                    remaining_d  = fifo_len_q[rd_ptr_q] - 16'd1;
                    loops_left_d = fifo_loops_q[rd_ptr_q];
                    addr_d       = fifo_start_q[rd_ptr_q];
                    strobe_d     = 1'b1;
                    state_d      = S_PLAY;
                end
            end
            S_PLAY: begin
                if (tick) begin
                    if (remaining_q != 16'd0) begin
                        addr_d      = addr_q + 16'd1;
                        remaining_d = remaining_q - 16'd1;
                        strobe_d    = 1'b1;
                    end else if (loops_left_q != 4'd0) begin
                        loops_left_d = loops_left_q - 4'd1;
                        addr_d       = start_q;
                        remaining_d  = len_q - 16'd1;
                        strobe_d     = 1'b1;
                    end else begin
                        done_d    = 1'b1;
                        tb_cnt_d  = '0;
                        gap_cnt_d = '0;
                        state_d   = (GAP_SAMPLES == 0) ? S_IDLE : S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (tick) begin
                    if (gap_cnt_q == GAP_LAST) begin
                        state_d = S_IDLE;
                    end else begin
                        gap_cnt_d = gap_cnt_q + 16'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Abort wins over everything except reset; cmd_ready already refuses its push.
        if (abort) begin
            state_d   = S_IDLE;
            tb_cnt_d  = '0;
            gap_cnt_d = '0;
            addr_d    = '0;
            strobe_d  = 1'b0;
            done_d    = 1'b0;
            level_d   = '0;
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
        end

        mute_d = !((state_d == S_PLAY) && enable);
        busy_d = (state_d != S_IDLE) || (level_d != 4'd0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            tb_cnt_q     <= '0;
            gap_cnt_q    <= '0;
            start_q      <= '0;
            len_q        <= '0;
            remaining_q  <= '0;
            loops_left_q <= '0;
            addr_q       <= '0;
            strobe_q     <= 1'b0;
            done_q       <= 1'b0;
            mute_q       <= 1'b1;
            busy_q       <= 1'b0;
            level_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_start_q[i] <= '0;
                fifo_len_q[i]   <= '0;
                fifo_loops_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            tb_cnt_q     <= tb_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            start_q      <= start_d;
            len_q        <= len_d;
            remaining_q  <= remaining_d;
            loops_left_q <= loops_left_d;
            addr_q       <= addr_d;
            strobe_q     <= strobe_d;
            done_q       <= done_d;
            mute_q       <= mute_d;
            busy_q       <= busy_d;
            level_q      <= level_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            fifo_start_q <= fifo_start_d;
            fifo_len_q   <= fifo_len_d;
            fifo_loops_q <= fifo_loops_d;
        end
    end

    assign sample_addr   = addr_q;
    assign sample_strobe = strobe_q;
    assign mute          = mute_q;
    assign busy          = busy_q;
    assign clip_done     = done_q;
    assign fifo_level    = level_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_audio_clip_sequencer.sv
// Directed bench for audio_clip_sequencer: each task drives one scenario and checks
// the outputs against hand-computed expectations.
module tb_audio_clip_sequencer;

    localparam int DIV = 195;
    localparam int GAP = 160;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] sample_addr;
    logic        sample_strobe;
    logic        mute;
    logic        busy;
    logic        clip_done;
    logic [3:0]  fifo_level;
    logic [1:0]  dbg_state;

    int total = 0;
    int bad   = 0;

    audio_clip_sequencer_if cmd_if ();

    audio_clip_sequencer #(
        .CLOCK_RATE  (3_125_000),
        .SAMPLE_RATE (16_000),
        .FIFO_DEPTH  (4),
        .GAP_SAMPLES (GAP)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .abort         (abort),
        .cmd           (cmd_if),
        .sample_addr   (sample_addr),
        .sample_strobe (sample_strobe),
        .mute          (mute),
        .busy          (busy),
        .clip_done     (clip_done),
        .fifo_level    (fifo_level),
        .dbg_state     (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Advance until a strobe or clip_done is seen, or the cycle budget expires.
    task automatic wait_evt(input int max_cyc, output int n, output bit s, output bit d);
        n = 0;
        s = 1'b0;
        d = 1'b0;
        while (n < max_cyc) begin
            step();
            n++;
            if (sample_strobe === 1'b1 || clip_done === 1'b1) begin
                s = sample_strobe;
                d = clip_done;
                break;
            end
        end
    endtask

    task automatic push_cmd(input logic [15:0] start, input logic [15:0] len, input logic [3:0] loops);
        cmd_if.cmd_start = start;
        cmd_if.cmd_len   = len;
        cmd_if.cmd_loops = loops;
        cmd_if.cmd_valid = 1'b1;
        step();
        cmd_if.cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        enable = 1'b1;
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_start = 16'h0042;
        cmd_if.cmd_len   = 16'd5;
        cmd_if.cmd_loops = 4'd0;
        step();
        step();
        total++; if (cmd_if.cmd_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", cmd_if.cmd_ready); end
        total++; if (sample_addr !== 16'h0000) begin bad++; $display("FAIL reset_addr got=%h want=0000", sample_addr); end
        total++; if (sample_strobe !== 1'b0) begin bad++; $display("FAIL reset_strobe got=%b want=0", sample_strobe); end
        total++; if (mute !== 1'b1) begin bad++; $display("FAIL reset_mute got=%b want=1", mute); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (clip_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", clip_done); end
        total++; if (fifo_level !== 4'd0) begin bad++; $display("FAIL reset_level got=%0d want=0", fifo_level); end
        cmd_if.cmd_valid = 1'b0;
        enable = 1'b0;
        rst_n = 1'b1;
        step();
        total++; if (fifo_level !== 4'd0) begin bad++; $display("FAIL reset_no_push got=%0d want=0", fifo_level); end
    endtask

    task automatic test_single_clip();
        int n;
        bit s;
        bit d;
        int strobes;
        int mute_bad;
        enable = 1'b1;
        push_cmd(16'd100, 16'd3, 4'd0);
        wait_evt(20, n, s, d);
        total++; if (s !== 1'b1) begin bad++; $display("FAIL clip1_strobe0 got=%b want=1", s); end
        total++; if (n !== 2) begin bad++; $display("FAIL clip1_latency got=%0d want=2", n); end
        total++; if (sample_addr !== 16'd100) begin bad++; $display("FAIL clip1_addr0 got=%0d want=100", sample_addr); end
        total++; if (mute !== 1'b0) begin bad++; $display("FAIL clip1_mute got=%b want=0", mute); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL clip1_busy got=%b want=1", busy); end
        for (int i = 1; i < 3; i++) begin
            wait_evt(400, n, s, d);
            total++; if (s !== 1'b1 || d !== 1'b0) begin bad++; $display("FAIL clip1_strobe%0d got s=%b d=%b want s=1 d=0", i, s, d); end
            total++; if (n !== DIV) begin bad++; $display("FAIL clip1_space%0d got=%0d want=%0d", i, n, DIV); end
            total++; if (sample_addr !== 16'(100 + i)) begin bad++; $display("FAIL clip1_addr%0d got=%0d want=%0d", i, sample_addr, 100 + i); end
        end
        wait_evt(400, n, s, d);
        total++; if (d !== 1'b1 || s !== 1'b0) begin bad++; $display("FAIL clip1_done got d=%b s=%b want d=1 s=0", d, s); end
        total++; if (n !== DIV) begin bad++; $display("FAIL clip1_done_delay got=%0d want=%0d", n, DIV); end
        total++; if (mute !== 1'b1) begin bad++; $display("FAIL clip1_gap_mute got=%b want=1", mute); end
        n = 0;
        strobes = 0;
        mute_bad = 0;
        while (busy === 1'b1 && n < 40000) begin
            step();
            n++;
            if (sample_strobe === 1'b1) strobes++;
            if (mute !== 1'b1) mute_bad++;
        end
        total++; if (n !== GAP * DIV) begin bad++; $display("FAIL clip1_gap_len got=%0d want=%0d", n, GAP * DIV); end
        total++; if (strobes !== 0) begin bad++; $display("FAIL clip1_gap_strobes got=%0d want=0", strobes); end
        total++; if (mute_bad !== 0) begin bad++; $display("FAIL clip1_gap_unmuted got=%0d want=0", mute_bad); end
        total++; if (dbg_state !== 2'd0) begin bad++; $display("FAIL clip1_idle got=%0d want=0", dbg_state); end
    endtask

    task automatic test_wrap_loops();
        int n;
        bit s;
        bit d;
        logic [15:0] exp_a [8];
        exp_a = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001, 16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
        push_cmd(16'hFFFE, 16'd4, 4'd1);
        for (int i = 0; i < 8; i++) begin
            wait_evt((i == 0) ? 20 : 400, n, s, d);
            total++; if (s !== 1'b1 || d !== 1'b0) begin bad++; $display("FAIL wrap_evt%0d got s=%b d=%b want s=1 d=0", i, s, d); end
            total++; if (sample_addr !== exp_a[i]) begin bad++; $display("FAIL wrap_addr%0d got=%h want=%h", i, sample_addr, exp_a[i]); end
            if (i > 0) begin
                total++; if (n !== DIV) begin bad++; $display("FAIL wrap_space%0d got=%0d want=%0d", i, n, DIV); end
            end
        end
        wait_evt(400, n, s, d);
        total++; if (d !== 1'b1 || n !== DIV) begin bad++; $display("FAIL wrap_done got d=%b n=%0d want d=1 n=%0d", d, n, DIV); end
        abort = 1'b1;
        step();
        abort = 1'b0;
        total++; if (busy !== 1'b0 || dbg_state !== 2'd0) begin bad++; $display("FAIL wrap_abort_gap got busy=%b state=%0d want 0 0", busy, dbg_state); end
    endtask

    task automatic test_fifo_fill();
        logic r;
        enable = 1'b0;
        cmd_if.cmd_start = 16'h0050;
        cmd_if.cmd_len   = 16'd0;
        cmd_if.cmd_loops = 4'd0;
        cmd_if.cmd_valid = 1'b1;
        #1;
        total++; if (cmd_if.cmd_ready !== 1'b1) begin bad++; $display("FAIL fill_len0_ready got=%b want=1", cmd_if.cmd_ready); end
        step();
        cmd_if.cmd_valid = 1'b0;
        total++; if (fifo_level !== 4'd0 || busy !== 1'b0) begin bad++; $display("FAIL fill_len0_drop got level=%0d busy=%b want 0 0", fifo_level, busy); end
        for (int i = 0; i < 5; i++) begin
            cmd_if.cmd_start = 16'(16'h0200 + i * 16'h0100);
            cmd_if.cmd_len   = 16'd2;
            cmd_if.cmd_loops = 4'd0;
            cmd_if.cmd_valid = 1'b1;
            #1;
            r = cmd_if.cmd_ready;
            total++; if (r !== ((i < 4) ? 1'b1 : 1'b0)) begin bad++; $display("FAIL fill_ready%0d got=%b want=%b", i, r, (i < 4)); end
            step();
        end
        cmd_if.cmd_valid = 1'b0;
        total++; if (fifo_level !== 4'd4) begin bad++; $display("FAIL fill_level got=%0d want=4", fifo_level); end
        total++; if (busy !== 1'b1 || sample_strobe !== 1'b0) begin bad++; $display("FAIL fill_idle got busy=%b strobe=%b want 1 0", busy, sample_strobe); end
    endtask

    task automatic test_abort();
        int n;
        bit s;
        bit d;
        int evts;
        enable = 1'b1;
        wait_evt(20, n, s, d);
        total++; if (s !== 1'b1 || sample_addr !== 16'h0200) begin bad++; $display("FAIL abort_head got s=%b addr=%h want 1 0200", s, sample_addr); end
        total++; if (fifo_level !== 4'd3) begin bad++; $display("FAIL abort_pop_level got=%0d want=3", fifo_level); end
        for (int i = 0; i < 50; i++) step();
        abort = 1'b1;
        cmd_if.cmd_start = 16'h0700;
        cmd_if.cmd_len   = 16'd2;
        cmd_if.cmd_valid = 1'b1;
        #1;
        total++; if (cmd_if.cmd_ready !== 1'b0) begin bad++; $display("FAIL abort_ready got=%b want=0", cmd_if.cmd_ready); end
        step();
        abort = 1'b0;
        cmd_if.cmd_valid = 1'b0;
        total++; if (fifo_level !== 4'd0) begin bad++; $display("FAIL abort_level got=%0d want=0", fifo_level); end
        total++; if (mute !== 1'b1 || sample_addr !== 16'h0000) begin bad++; $display("FAIL abort_out got mute=%b addr=%h want 1 0000", mute, sample_addr); end
        total++; if (busy !== 1'b0 || dbg_state !== 2'd0) begin bad++; $display("FAIL abort_idle got busy=%b state=%0d want 0 0", busy, dbg_state); end
        evts = 0;
        for (int i = 0; i < 600; i++) begin
            if (clip_done === 1'b1 || sample_strobe === 1'b1) evts++;
            step();
        end
        total++; if (evts !== 0) begin bad++; $display("FAIL abort_quiet got=%0d want=0", evts); end
    endtask

    task automatic test_load_push_freeze();
        int n;
        bit s;
        bit d;
        int strobes;
        int mute_bad;
        enable = 1'b0;
        push_cmd(16'h1234, 16'd3, 4'd0);
        enable = 1'b1;
        step();
        total++; if (dbg_state !== 2'd1) begin bad++; $display("FAIL lp_load_state got=%0d want=1", dbg_state); end
        cmd_if.cmd_start = 16'h5000;
        cmd_if.cmd_len   = 16'd2;
        cmd_if.cmd_loops = 4'd0;
        cmd_if.cmd_valid = 1'b1;
        #1;
        total++; if (cmd_if.cmd_ready !== 1'b1) begin bad++; $display("FAIL lp_ready got=%b want=1", cmd_if.cmd_ready); end
        step();
        cmd_if.cmd_valid = 1'b0;
        total++; if (fifo_level !== 4'd1) begin bad++; $display("FAIL lp_level got=%0d want=1", fifo_level); end
        total++; if (sample_strobe !== 1'b1 || sample_addr !== 16'h1234) begin bad++; $display("FAIL lp_strobe got s=%b addr=%h want 1 1234", sample_strobe, sample_addr); end
        for (int i = 0; i < 100; i++) step();
        enable = 1'b0;
        strobes = 0;
        mute_bad = 0;
        for (int i = 0; i < 1000; i++) begin
            step();
            if (sample_strobe === 1'b1) strobes++;
            if (mute !== 1'b1) mute_bad++;
        end
        total++; if (strobes !== 0 || mute_bad !== 0) begin bad++; $display("FAIL freeze_quiet got strobes=%0d unmuted=%0d want 0 0", strobes, mute_bad); end
        total++; if (dbg_state !== 2'd2) begin bad++; $display("FAIL freeze_state got=%0d want=2", dbg_state); end
        enable = 1'b1;
        wait_evt(400, n, s, d);
        total++; if (s !== 1'b1 || n !== DIV - 100) begin bad++; $display("FAIL freeze_resume got s=%b n=%0d want 1 %0d", s, n, DIV - 100); end
        total++; if (sample_addr !== 16'h1235 || mute !== 1'b0) begin bad++; $display("FAIL freeze_addr got addr=%h mute=%b want 1235 0", sample_addr, mute); end
    endtask

    task automatic test_reset_mid_play();
        int strobes;
        for (int i = 0; i < 20; i++) step();
        rst_n = 1'b0;
        #1;
        total++; if (cmd_if.cmd_ready !== 1'b0) begin bad++; $display("FAIL rst_mid_ready got=%b want=0", cmd_if.cmd_ready); end
        step();
        total++; if (sample_addr !== 16'h0000 || sample_strobe !== 1'b0 || clip_done !== 1'b0) begin bad++; $display("FAIL rst_mid_out got addr=%h s=%b d=%b want 0000 0 0", sample_addr, sample_strobe, clip_done); end
        total++; if (mute !== 1'b1 || busy !== 1'b0 || fifo_level !== 4'd0) begin bad++; $display("FAIL rst_mid_flags got mute=%b busy=%b level=%0d want 1 0 0", mute, busy, fifo_level); end
        rst_n = 1'b1;
        strobes = 0;
        for (int i = 0; i < 500; i++) begin
            step();
            if (sample_strobe === 1'b1) strobes++;
        end
        total++; if (strobes !== 0 || busy !== 1'b0) begin bad++; $display("FAIL rst_mid_lost got strobes=%0d busy=%b want 0 0", strobes, busy); end
    endtask

    initial begin
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_start = 16'h0000;
        cmd_if.cmd_len   = 16'd0;
        cmd_if.cmd_loops = 4'd0;
        test_reset();
        test_single_clip();
        test_wrap_loops();
        test_fifo_fill();
        test_abort();
        test_load_push_freeze();
        test_reset_mid_play();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
